// File: rtl/sample_ser_tx_pkg.sv
// Shared types and defaults for the sample serializer and its neighbours in the decimation chain.
package sample_ser_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_DIV   = 4;

  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sample_ser_tx_fifo.sv
// Single-clock sample FIFO; occupancy is tracked separately from the pointers.
module sample_fifo
  import sample_ser_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rstx_i,
  input  logic                        clr_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [WIDTH-1:0]            data_i,
  output logic [WIDTH-1:0]            data_o,
  output logic [lvl_width(DEPTH)-1:0] level_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // When full, a same-cycle pop frees exactly the slot this push lands in
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstx_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sample_ser_tx.sv
// Serializes buffered samples onto a framed 3-wire link (sclk/fs/sd), MSB first,
// with a fixed idle gap after every word and a sticky overflow flag.
module sample_ser_tx
  import sample_ser_tx_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic                        clk,
  input  logic                        rstx,
  input  logic                        clear,
  input  logic                        enable,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        sclk_out,
  output logic                        fs_out,
  output logic                        sd_out,
  output logic                        busy,
  output logic [lvl_width(DEPTH)-1:0] level,
  output logic                        overflow
);

  localparam int unsigned PW = $clog2(2 * DIV);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = $clog2(GAP_BITS + 1);

  ser_state_e       state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sclk_q, fs_q, sd_q, busy_q, ovf_q;

  logic             pop;
  logic             period_end;
  logic             start_ok;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_full, fifo_empty;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rstx_i  (rstx),
    .clr_i   (clear),
    .push_i  (in_valid),
    .pop_i   (pop),
    .data_i  (in_data),
    .data_o  (fifo_data),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign period_end = (phase_q == PW'(2 * DIV - 1));
  assign start_ok   = enable && !fifo_empty;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_d = ST_SHIFT;
          sh_d    = fifo_data;
          bit_d   = BW'(WIDTH - 1);
          phase_d = '0;
        end
      end
      ST_SHIFT: begin
        phase_d = period_end ? '0 : phase_q + PW'(1);
        if (period_end) begin
          if (bit_q == '0) begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP_BITS - 1);
            sh_d    = '0;
          end else begin
            bit_d = bit_q - BW'(1);
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      ST_GAP: begin
        phase_d = period_end ? '0 : phase_q + PW'(1);
        if (period_end) begin
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else if (start_ok) begin
            // Chain straight into the next word so frames stay back-to-back
            pop     = 1'b1;
            state_d = ST_SHIFT;
            sh_d    = fifo_data;
            bit_d   = BW'(WIDTH - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Link outputs are registered from next-state values so they change with the state
  always_ff @(posedge clk) begin
    if (!rstx || clear) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      fs_q    <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      sclk_q  <= (state_d != ST_IDLE) && (phase_d >= PW'(DIV));
      fs_q    <= (state_d == ST_SHIFT) && (bit_d == BW'(WIDTH - 1));
      sd_q    <= (state_d == ST_SHIFT) && sh_d[WIDTH-1];
      busy_q  <= (state_d != ST_IDLE);
      if (in_valid && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign sclk_out = sclk_q;
  assign fs_out   = fs_q;
  assign sd_out   = sd_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sample_ser_tx.sv
// Directed bench for sample_ser_tx with DIV=2, DEPTH=4, GAP_BITS=1.
module tb_sample_ser_tx;

  logic        clk = 1'b0;
  logic        rstx, clear, enable, in_valid;
  logic [15:0] in_data;
  logic        sclk_out, fs_out, sd_out, busy, overflow;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  sample_ser_tx #(
    .WIDTH    (16),
    .DEPTH    (4),
    .DIV      (2),
    .GAP_BITS (1)
  ) dut (
    .clk      (clk),
    .rstx     (rstx),
    .clear    (clear),
    .enable   (enable),
    .in_valid (in_valid),
    .in_data  (in_data),
    .sclk_out (sclk_out),
    .fs_out   (fs_out),
    .sd_out   (sd_out),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  // Called in the first cycle of a frame; walks 16 bits x 4 cycles plus the 4-cycle gap
  task automatic expect_frame(input logic [15:0] w, input int drop_at);
    int   b;
    logic esd, efs;
    for (int k = 0; k < 68; k++) begin
      if (k == drop_at) enable = 1'b0;
      if (k < 64) begin
        b   = 15 - k / 4;
        esd = w[b];
        efs = (b == 15);
      end else begin
        esd = 1'b0;
        efs = 1'b0;
      end
      chk($sformatf("sd %h c%0d", w, k), {31'd0, sd_out}, {31'd0, esd});
      chk($sformatf("fs %h c%0d", w, k), {31'd0, fs_out}, {31'd0, efs});
      chk($sformatf("sclk %h c%0d", w, k), {31'd0, sclk_out}, {31'd0, ((k % 4) >= 2)});
      chk($sformatf("busy %h c%0d", w, k), {31'd0, busy}, 32'd1);
      step();
    end
  endtask

  task automatic idle_chk(input string tag, input logic [2:0] exp_level);
    chk({tag, " sclk"}, {31'd0, sclk_out}, 32'd0);
    chk({tag, " sd"}, {31'd0, sd_out}, 32'd0);
    chk({tag, " fs"}, {31'd0, fs_out}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " level"}, {29'd0, level}, {29'd0, exp_level});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstx = 1'b0; clear = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    step(2);
    idle_chk("reset", 3'd0);
    chk("reset ovf", {31'd0, overflow}, 32'd0);
    rstx = 1'b1;

    // Single word: fs from 2 cycles after the push
    enable = 1'b1;
    push(16'hA5C3);
    chk("single level", {29'd0, level}, 32'd1);
    chk("single busy", {31'd0, busy}, 32'd0);
    step();
    expect_frame(16'hA5C3, -1);
    idle_chk("single end", 3'd0);

    // Back-to-back words with one gap between them
    in_valid = 1'b1;
    in_data  = 16'h0001;
    step();
    chk("b2b level1", {29'd0, level}, 32'd1);
    in_data = 16'h8000;
    step();
    in_valid = 1'b0;
    chk("b2b level2", {29'd0, level}, 32'd1);
    expect_frame(16'h0001, -1);
    expect_frame(16'h8000, -1);
    idle_chk("b2b end", 3'd0);

    // Overflow: fifth word dropped
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push(16'h1111 * i[15:0]);
      chk($sformatf("ovf level%0d", i), {29'd0, level}, (i > 4) ? 32'd4 : i);
      chk($sformatf("ovf flag%0d", i), {31'd0, overflow}, (i > 4) ? 32'd1 : 32'd0);
    end
    enable = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) expect_frame(16'h1111 * i[15:0], -1);
    idle_chk("ovf end", 3'd0);
    chk("ovf sticky", {31'd0, overflow}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("ovf cleared", {31'd0, overflow}, 32'd0);

    // Push on the pop edge while full
    enable = 1'b0;
    push(16'h1234);
    push(16'h5678);
    push(16'h9ABC);
    push(16'hDEF0);
    chk("full level", {29'd0, level}, 32'd4);
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0F0F;
    step();
    in_valid = 1'b0;
    chk("pushpop level", {29'd0, level}, 32'd4);
    chk("pushpop ovf", {31'd0, overflow}, 32'd0);
    expect_frame(16'h1234, -1);
    expect_frame(16'h5678, -1);
    expect_frame(16'h9ABC, -1);
    expect_frame(16'hDEF0, -1);
    expect_frame(16'h0F0F, -1);
    idle_chk("pushpop end", 3'd0);
    chk("pushpop ovf end", {31'd0, overflow}, 32'd0);

    // Enable dropped at bit 8 of the first of two words
    push(16'hC0DE);
    push(16'h7E57);
    chk("drop level", {29'd0, level}, 32'd1);
    expect_frame(16'hC0DE, 28);
    idle_chk("drop idle", 3'd1);
    step(5);
    idle_chk("drop hold", 3'd1);
    enable = 1'b1;
    step();
    expect_frame(16'h7E57, -1);
    idle_chk("drop end", 3'd0);

    // Reset at bit 10
    push(16'hFFFF);
    push(16'h1357);
    step(22);
    chk("rst pre sd", {31'd0, sd_out}, 32'd1);
    chk("rst pre sclk", {31'd0, sclk_out}, 32'd1);
    rstx = 1'b0;
    step();
    rstx = 1'b1;
    idle_chk("rst", 3'd0);
    chk("rst ovf", {31'd0, overflow}, 32'd0);
    step();
    chk("rst stay idle", {31'd0, busy}, 32'd0);

    // Clear at bit 10 with a full FIFO and a coincident sample
    push(16'hFFFF);
    step();
    for (int i = 0; i < 4; i++) push(16'h2222);
    chk("clr pre level", {29'd0, level}, 32'd4);
    step(18);
    chk("clr pre sd", {31'd0, sd_out}, 32'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h9999;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    idle_chk("clr", 3'd0);
    chk("clr ovf", {31'd0, overflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_ser_tx.md
Name: sample_ser_tx

Overview:
- Output side of the sensor decimation chain: consumes the 16-bit `data_out` / `data_out_valid` sample stream and serializes each sample onto a 3-wire framed serial link (`sclk_out`, `fs_out`, `sd_out`) toward an external host.
- Has no backpressure toward the filter chain. A small FIFO absorbs jitter between the decimated sample rate and the link rate.
- Overruns are flagged and never stall upstream logic.

Parameters:
- WIDTH, 16, sample width in bits; matches the filter chain output.
- DEPTH, 4, FIFO depth in samples; must be a power of two and at least 2.
- DIV, 4, half bit period in clk cycles; must be at least 1. One bit period is 2*DIV cycles.
- GAP_BITS, 1, idle bit periods inserted after each word; must be at least 1.

Ports:
- clk  input  1  system clock.
- rstx  input  1  synchronous, active-low reset.
- clear  input  1  synchronous flush of FIFO, serializer and overflow flag.
- enable  input  1  allows new words to start transmitting.
- in_valid  input  1  one-cycle sample strobe, driven from `data_out_valid`.
- in_data  input  WIDTH  sample, driven from `data_out`; sampled when in_valid=1.
- sclk_out  output  1  serial bit clock; low when idle.
- fs_out  output  1  frame sync; high during the first (MSB) bit period of each word.
- sd_out  output  1  serial data, MSB first; 0 when not shifting.
- busy  output  1  1 in SHIFT or GAP.
- level  output  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  output  1  sticky; set when a sample is dropped.

Behaviour:
- Reset (rstx=0 at a clk edge): on the next cycle all outputs are 0, the FIFO is empty, and state is IDLE. Reset mid-word aborts the word with no trailing bits.
- clear=1: same effect as reset, but only when rstx=1. clear has priority over in_valid: a sample presented in the same cycle is discarded and does not set overflow.
- FIFO write rule: in_valid=1 and FIFO not full → write.
- FIFO full case: in_valid=1 and FIFO full with no pop in the same cycle → sample dropped, overflow set to 1.
- Simultaneous push and pop when full: both succeed, level unchanged, no overflow.
- level reflects writes and pops made on the previous clk edge.
- FSM states: IDLE, SHIFT, GAP.
- IDLE → SHIFT: when enable=1 and level>0. Pop the head word into the shift register on that edge, bit counter = WIDTH-1, phase counter = 0.
- SHIFT, per bit period of 2*DIV cycles:
  - sclk_out=0 for phase 0..DIV-1 and 1 for phase DIV..2*DIV-1.
  - sd_out holds the current bit for the whole period. It changes only when sclk_out goes low, so the host samples on the sclk rising edge.
  - fs_out=1 only during the bit-(WIDTH-1) period.
  - After the bit-0 period → GAP.
- GAP: sclk_out keeps toggling with the same period; sd_out=0, fs_out=0. After GAP_BITS periods:
  - enable=1 and level>0 → pop and go to SHIFT (back-to-back words, no extra cycle).
  - otherwise → IDLE, with sclk_out=0.
- Deasserting enable mid-word or mid-gap does not truncate; the current word and its gap complete, then the FSM goes to IDLE.
- Latency: in_valid at edge t into an empty FIFO, with IDLE and enable=1 → level=1 at t+1, pop at t+1 edge, sd_out=MSB and fs_out=1 from t+2.
- Frame length: WIDTH*2*DIV + GAP_BITS*2*DIV cycles. Sustained throughput is one word per frame length.
- Internal pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately so full and empty are unambiguous.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - state enum typedef (IDLE, SHIFT, GAP);
  - a function computing the level width;
  - default WIDTH/DEPTH/DIV constants reused by the filter-chain top.
- One natural sub-module: `sample_fifo` (synchronous single-clock FIFO with push, pop, level and full/empty; no overflow logic).
- The FSM and serializer stay in `sample_ser_tx`.

Test Plan (DIV=2, DEPTH=4, GAP_BITS=1 unless stated):
- Single word: push 16'hA5C3 with enable=1 → fs_out high for cycles 2..5 after the push. sd_out bit sequence is 1010_0101_1100_0011, each bit held 4 cycles. Then a 4-cycle gap, then IDLE with sclk_out=0.
- Back-to-back: push 16'h0001 and 16'h8000 one cycle apart → two frames separated by exactly one 4-cycle gap. Second fs_out rises 68 cycles after the first. No IDLE cycle between frames.
- Overflow: enable=0, push 5 words 16'h1111..16'h5555 → level=4, overflow=1 after the 5th push. Then raise enable → only 16'h1111..16'h4444 are transmitted, in order.
- Full push+pop: fill 4 words, then push exactly on the pop edge → level stays 4, overflow stays 0, and the new word is transmitted 5th.
- Enable drop mid-word: deassert enable at bit 8 with 2 words queued → current word completes fully, then IDLE. level=1 is retained. Re-enable transmits the remaining word.
- Reset/clear mid-word: assert rstx=0 for one cycle at bit 10 → next cycle sclk_out=sd_out=fs_out=busy=0 and level=0. Repeat with clear=1 and in_valid=1 on the same cycle → level=0, overflow=0.
